// File: rtl/mem_arbiter.sv
// Single-port memory arbiter and pipeline stall controller: serialises the data access and the
// instruction fetch onto one backing memory. Optional ack timeout is enabled by MEM_ARB_TIMEOUT_EN.
module mem_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  input  logic        dm_read_i,
  input  logic        dm_write_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DM_BUSY = 2'd1,
    IF_BUSY = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        dm_done_q, dm_done_d;
  logic        if_done_q, if_done_d;
  logic        dm_pend, if_pend, stall;
  logic        dm_done_set, if_done_set;
  logic        ack_eff;
  logic [31:0] ack_data;

  logic        mem_req_d, mem_we_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] dm_rdata_q, dm_rdata_d;

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  assign dm_pend = (dm_read_i | dm_write_i) & ~dm_done_q;
  assign if_pend = if_req_i & ~if_done_q;

  // Gated by reset so the pipeline sees no stall while reset is held.
  assign stall   = rst_i & (dm_pend | if_pend);
  assign stall_o = stall;

  assign if_data_o  = if_data_q;
  assign dm_rdata_o = dm_rdata_q;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W    = (CNT_BITS > 8) ? CNT_BITS : 8;

  logic [CNT_W-1:0] busy_cnt_q;
  logic             timeout;
  logic             err_q;

  // Counter is 0 in the first BUSY cycle, so the limit hits in BUSY cycle TIMEOUT_CYCLES.
  assign timeout = (state_q != IDLE) && (busy_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // A real ack arriving together with the limit wins and is not an error.
  assign ack_eff  = mem_ack_i | timeout;
  assign ack_data = mem_ack_i ? mem_rdata_i : 32'h0000_0000;
  assign err_o    = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      busy_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (state_q == IDLE) busy_cnt_q <= '0;
      else                 busy_cnt_q <= busy_cnt_q + 1'b1;
      if (timeout && !mem_ack_i) err_q <= 1'b1;
    end
  end
`else
  assign ack_eff  = mem_ack_i;
  assign ack_data = mem_rdata_i;
  assign err_o    = 1'b0;
`endif

  // Next-state and registered-output logic.
  // NOTE: every variable gets a default before the case so no path leaves one unassigned;
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_o;
    mem_we_d    = mem_we_o;
    mem_addr_d  = mem_addr_o;
    mem_wdata_d = mem_wdata_o;
    dm_rdata_d  = dm_rdata_q;
    if_data_d   = if_data_q;
    dm_done_set = 1'b0;
    if_done_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Data first: it belongs to the older instruction.
        if (dm_pend) begin
          mem_addr_d  = dm_addr_i;
          mem_wdata_d = dm_wdata_i;
          mem_we_d    = dm_write_i;
          mem_req_d   = 1'b1;
          state_d     = DM_BUSY;
        end else if (if_pend) begin
          mem_addr_d  = if_addr_i;
          mem_we_d    = 1'b0;
          mem_req_d   = 1'b1;
          state_d     = IF_BUSY;
        end
      end
      DM_BUSY: begin
        if (ack_eff) begin
          mem_req_d   = 1'b0;
          dm_done_set = 1'b1;
          if (!mem_we_o) dm_rdata_d = ack_data;
          state_d     = IDLE;
        end
      end
      IF_BUSY: begin
        if (ack_eff) begin
          mem_req_d   = 1'b0;
          if_done_set = 1'b1;
          if_data_d   = ack_data;
          state_d     = IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    // The pipeline advances on every edge without stall, retiring both done flags.
    // A clear must win over a set, or a completion for a withdrawn request would
    // mask the next instruction's access.
    dm_done_d = stall & (dm_done_q | dm_done_set);
    if_done_d = stall & (if_done_q | if_done_set);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the hold registers are plain flops, not a memory array, so they are reset
  // like any other state and read 0 after reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 32'h0000_0000;
      mem_wdata_o <= 32'h0000_0000;
      dm_rdata_q  <= 32'h0000_0000;
      if_data_q   <= 32'h0000_0000;
      dm_done_q   <= 1'b0;
      if_done_q   <= 1'b0;
    end else begin
      mem_req_o   <= mem_req_d;
      mem_we_o    <= mem_we_d;
      mem_addr_o  <= mem_addr_d;
      mem_wdata_o <= mem_wdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_data_q   <= if_data_d;
      dm_done_q   <= dm_done_d;
      if_done_q   <= if_done_d;
    end
  end

endmodule
